// File: rtl/usb_mem_bridge.sv
// usb_mem_bridge: host-side register window onto a 16-bit memory pointer.
// Pointer, CONTROL and STATUS accesses complete in one cycle. DATA accesses
// become a held memory request, and a wait counter bounds the request at
// TIMEOUT cycles so that a dead memory port cannot hang the host.
module usb_mem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_wr,
  input  logic        host_rd,
  input  logic [7:0]  host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        host_done,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        cpu_halt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] ADDR_PTR_LO  = 8'd0;
  localparam logic [7:0] ADDR_PTR_HI  = 8'd1;
  localparam logic [7:0] ADDR_DATA    = 8'd2;
  localparam logic [7:0] ADDR_CONTROL = 8'd3;
  localparam logic [7:0] ADDR_STATUS  = 8'd4;

  // The counter starts at 0 in the first MEM cycle, so its last legal value
  // is TIMEOUT-1; reaching it without an ack ends the access.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  // Only the halt (bit0) and autoinc (bit1) CONTROL bits exist; the rest read 0.
  logic [1:0]  ctrl_q, ctrl_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  wait_q, wait_d;

  logic [7:0]  regRead;
  logic        memEnd;
  logic        timedOut;
  logic        clearErr;

  // Read mux for the directly readable registers; DATA and unmapped read 0.
  always_comb begin
    regRead = 8'h00;
    case (host_addr)
      ADDR_PTR_LO:  regRead = ptr_q[7:0];
      ADDR_PTR_HI:  regRead = ptr_q[15:8];
      ADDR_CONTROL: regRead = {6'b0, ctrl_q};
      ADDR_STATUS:  regRead = {6'b0, err_q, (state_q != IDLE)};
      default:      regRead = 8'h00;
    endcase
  end

  // Next-state logic: host acceptance in IDLE, memory handshake and timeout in MEM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ctrl_d   = ctrl_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    req_d    = req_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    memEnd   = 1'b0;
    timedOut = 1'b0;
    clearErr = 1'b0;

    case (state_q)
      IDLE: begin
        if (host_wr || host_rd) begin
          if (host_addr == ADDR_DATA) begin
            state_d = MEM;
            req_d   = 1'b1;
            we_d    = host_wr;
            wait_d  = 8'd0;
            if (host_wr) begin
              wdata_d = host_wdata;
            end
          end else begin
            state_d = DONE;
            if (host_wr) begin
              case (host_addr)
                ADDR_PTR_LO:  ptr_d[7:0]  = host_wdata;
                ADDR_PTR_HI:  ptr_d[15:8] = host_wdata;
                ADDR_CONTROL: ctrl_d      = host_wdata[1:0];
                ADDR_STATUS:  clearErr    = host_wdata[1];
                default:      ;
              endcase
            end else begin
              rdata_d = regRead;
            end
          end
        end
      end

      MEM: begin
        if (mem_ack) begin
          memEnd = 1'b1;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end else if (wait_q == TIMEOUT_LAST) begin
          memEnd   = 1'b1;
          timedOut = 1'b1;
          if (!we_q) begin
            rdata_d = 8'hFF;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end

        if (memEnd) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (ctrl_q[1]) begin
            ptr_d = ptr_q + 16'd1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh timeout outranks a simultaneous write-1-to-clear.
    if (timedOut) begin
      err_d = 1'b1;
    end else if (clearErr) begin
      err_d = 1'b0;
    end
  end

  // State and register update; reset abandons any in-flight memory access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 16'h0000;
      ctrl_q  <= 2'b10;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
    end
  end

  assign host_rdata = rdata_q;
  assign host_done  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign mem_addr   = ptr_q;
  assign mem_wdata  = wdata_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign cpu_halt   = ctrl_q[0];

endmodule

// File: tb/tb_usb_mem_bridge.sv
// tb_usb_mem_bridge: directed and randomized host accesses against a
// register-level reference model of the bridge.
module tb_usb_mem_bridge;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        reset;
  logic        host_wr;
  logic        host_rd;
  logic [7:0]  host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        host_done;
  logic        busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        cpu_halt;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the host should see through the register map.
  logic [15:0] mPtr;
  logic [1:0]  mCtrl;
  logic        mErr;
  logic [7:0]  mRdata;

  // Observations captured by the access driver.
  int          lastLatency;
  int          lastReqCycles;
  logic        lastBusyOk;
  logic [15:0] lastAddr;
  logic        lastWe;
  logic [7:0]  lastWdata;
  logic [7:0]  lastRdata;
  logic        lastReqAtDone;
  logic        lastPostDone;
  logic        lastPostBusy;

  usb_mem_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .host_wr   (host_wr),
    .host_rd   (host_rd),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .host_done (host_done),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .cpu_halt  (cpu_halt)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void modelReset();
    mPtr   = 16'h0000;
    mCtrl  = 2'b10;
    mErr   = 1'b0;
    mRdata = 8'h00;
  endfunction

  function automatic logic [7:0] modelRegRead(input logic [7:0] addr);
    case (addr)
      8'd0:    return mPtr[7:0];
      8'd1:    return mPtr[15:8];
      8'd3:    return {6'b0, mCtrl};
      8'd4:    return {6'b0, mErr, 1'b0};
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit ackWithinLimit(input int ackDelay);
    return (ackDelay >= 0) && (ackDelay < TIMEOUT);
  endfunction

  function automatic int expLatency(input logic [7:0] addr, input int ackDelay);
    if (addr != 8'd2) return 1;
    if (ackWithinLimit(ackDelay)) return ackDelay + 2;
    return TIMEOUT + 1;
  endfunction

  function automatic int expReqCycles(input logic [7:0] addr, input int ackDelay);
    if (addr != 8'd2) return 0;
    if (ackWithinLimit(ackDelay)) return ackDelay + 1;
    return TIMEOUT;
  endfunction

  // Apply one completed access to the model (wr wins over rd).
  function automatic void modelAccess(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                                      input int ackDelay, input logic [7:0] memData);
    if (addr == 8'd2) begin
      if (ackWithinLimit(ackDelay)) begin
        if (!wr) mRdata = memData;
      end else begin
        mErr = 1'b1;
        if (!wr) mRdata = 8'hFF;
      end
      if (mCtrl[1]) mPtr = mPtr + 16'd1;
    end else if (wr) begin
      case (addr)
        8'd0: mPtr[7:0]  = wdata;
        8'd1: mPtr[15:8] = wdata;
        8'd3: mCtrl      = wdata[1:0];
        8'd4: if (wdata[1]) mErr = 1'b0;
        default: ;
      endcase
    end else begin
      mRdata = modelRegRead(addr);
    end
  endfunction

  // Drive one host pulse, play the memory side, and record what was seen.
  // ackDelay counts request cycles before the ack (negative = never ack).
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] addr,
                               input logic [7:0] wdata, input int ackDelay, input logic [7:0] memData);
    @(negedge clk);
    host_wr    = wr;
    host_rd    = rd;
    host_addr  = addr;
    host_wdata = wdata;
    @(negedge clk);
    host_wr = 1'b0;
    host_rd = 1'b0;
    lastLatency   = 1;
    lastReqCycles = 0;
    lastBusyOk    = 1'b1;
    lastAddr      = 16'hxxxx;
    lastWe        = 1'bx;
    lastWdata     = 8'hxx;
    while (host_done !== 1'b1 && lastLatency < 300) begin
      if (busy !== 1'b1) lastBusyOk = 1'b0;
      if (mem_req === 1'b1) begin
        if (lastReqCycles == 0) begin
          lastAddr  = mem_addr;
          lastWe    = mem_we;
          lastWdata = mem_wdata;
        end
        lastReqCycles++;
        if (lastReqCycles - 1 == ackDelay) begin
          mem_ack   = 1'b1;
          mem_rdata = memData;
        end
      end
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      lastLatency++;
    end
    if (busy !== 1'b1) lastBusyOk = 1'b0;
    lastReqAtDone = mem_req;
    lastRdata     = host_rdata;
    @(negedge clk);
    lastPostDone = host_done;
    lastPostBusy = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 00", host_rdata); end
    checks++; if ({host_done, busy, mem_req, mem_we, cpu_halt} !== 5'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00000", {host_done, busy, mem_req, mem_we, cpu_halt}); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h expected 00", mem_wdata); end
    reset = 1'b0;
    modelReset();
    applyStimulus(1'b0, 1'b1, 8'd3, 8'h00, -1, 8'h00);
    modelAccess(1'b0, 8'd3, 8'h00, -1, 8'h00);
    checks++; if (lastRdata !== 8'h02) begin errors++; $display("[TB] FAIL reset_control: got %h expected 02", lastRdata); end
    applyStimulus(1'b0, 1'b1, 8'd4, 8'h00, -1, 8'h00);
    modelAccess(1'b0, 8'd4, 8'h00, -1, 8'h00);
    checks++; if (lastRdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_status: got %h expected 00", lastRdata); end
  endtask

  task automatic test_pointer_regs();
    applyStimulus(1'b1, 1'b0, 8'd0, 8'h34, -1, 8'h00);
    modelAccess(1'b1, 8'd0, 8'h34, -1, 8'h00);
    checks++; if (lastLatency !== 1) begin errors++; $display("[TB] FAIL ptr_lo_wr_latency: got %0d expected 1", lastLatency); end
    checks++; if (lastPostDone !== 1'b0 || lastPostBusy !== 1'b0 || lastBusyOk !== 1'b1) begin errors++; $display("[TB] FAIL ptr_lo_wr_pulse: done_after %b busy_after %b busy_ok %b expected 0 0 1", lastPostDone, lastPostBusy, lastBusyOk); end
    applyStimulus(1'b1, 1'b0, 8'd1, 8'h12, -1, 8'h00);
    modelAccess(1'b1, 8'd1, 8'h12, -1, 8'h00);
    checks++; if (lastLatency !== 1) begin errors++; $display("[TB] FAIL ptr_hi_wr_latency: got %0d expected 1", lastLatency); end
    applyStimulus(1'b0, 1'b1, 8'd0, 8'h00, -1, 8'h00);
    modelAccess(1'b0, 8'd0, 8'h00, -1, 8'h00);
    checks++; if (lastRdata !== 8'h34 || lastLatency !== 1) begin errors++; $display("[TB] FAIL ptr_lo_read: got %h latency %0d expected 34 latency 1", lastRdata, lastLatency); end
    applyStimulus(1'b0, 1'b1, 8'd1, 8'h00, -1, 8'h00);
    modelAccess(1'b0, 8'd1, 8'h00, -1, 8'h00);
    checks++; if (lastRdata !== 8'h12) begin errors++; $display("[TB] FAIL ptr_hi_read: got %h expected 12", lastRdata); end
    checks++; if (mem_addr !== 16'h1234) begin errors++; $display("[TB] FAIL ptr_mem_addr: got %h expected 1234", mem_addr); end
  endtask

  task automatic test_data_write();
    applyStimulus(1'b1, 1'b0, 8'd2, 8'hAB, 3, 8'h00);
    checks++; if (lastAddr !== 16'h1234 || lastWe !== 1'b1 || lastWdata !== 8'hAB) begin errors++; $display("[TB] FAIL data_wr_request: addr %h we %b wdata %h expected 1234 1 AB", lastAddr, lastWe, lastWdata); end
    checks++; if (lastLatency !== 5 || lastReqCycles !== 4) begin errors++; $display("[TB] FAIL data_wr_timing: latency %0d req_cycles %0d expected 5 4", lastLatency, lastReqCycles); end
    checks++; if (lastReqAtDone !== 1'b0) begin errors++; $display("[TB] FAIL data_wr_req_drop: got %b expected 0", lastReqAtDone); end
    modelAccess(1'b1, 8'd2, 8'hAB, 3, 8'h00);
    checks++; if (mem_addr !== 16'h1235 || mem_addr !== mPtr) begin errors++; $display("[TB] FAIL data_wr_autoinc: got %h expected 1235", mem_addr); end
  endtask

  task automatic test_data_read_wrap();
    applyStimulus(1'b1, 1'b0, 8'd0, 8'hFF, -1, 8'h00);
    modelAccess(1'b1, 8'd0, 8'hFF, -1, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'd1, 8'hFF, -1, 8'h00);
    modelAccess(1'b1, 8'd1, 8'hFF, -1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'd2, 8'h00, 0, 8'h5A);
    checks++; if (lastAddr !== 16'hFFFF || lastWe !== 1'b0) begin errors++; $display("[TB] FAIL data_rd_request: addr %h we %b expected FFFF 0", lastAddr, lastWe); end
    checks++; if (lastRdata !== 8'h5A || lastLatency !== 2) begin errors++; $display("[TB] FAIL data_rd_value: got %h latency %0d expected 5A latency 2", lastRdata, lastLatency); end
    modelAccess(1'b0, 8'd2, 8'h00, 0, 8'h5A);
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL data_rd_wrap: got %h expected 0000", mem_addr); end
  endtask

  task automatic test_timeout();
    applyStimulus(1'b0, 1'b1, 8'd2, 8'h00, -1, 8'h00);
    checks++; if (lastReqCycles !== TIMEOUT || lastLatency !== TIMEOUT + 1) begin errors++; $display("[TB] FAIL timeout_timing: req_cycles %0d latency %0d expected %0d %0d", lastReqCycles, lastLatency, TIMEOUT, TIMEOUT + 1); end
    checks++; if (lastRdata !== 8'hFF) begin errors++; $display("[TB] FAIL timeout_rdata: got %h expected FF", lastRdata); end
    modelAccess(1'b0, 8'd2, 8'h00, -1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'd4, 8'h00, -1, 8'h00);
    modelAccess(1'b0, 8'd4, 8'h00, -1, 8'h00);
    checks++; if (lastRdata !== 8'h02) begin errors++; $display("[TB] FAIL timeout_status: got %h expected 02", lastRdata); end
    applyStimulus(1'b1, 1'b0, 8'd4, 8'h02, -1, 8'h00);
    modelAccess(1'b1, 8'd4, 8'h02, -1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'd4, 8'h00, -1, 8'h00);
    modelAccess(1'b0, 8'd4, 8'h00, -1, 8'h00);
    checks++; if (lastRdata !== 8'h00) begin errors++; $display("[TB] FAIL status_w1c: got %h expected 00", lastRdata); end
  endtask

  task automatic test_ignore_and_halt();
    applyStimulus(1'b1, 1'b0, 8'd0, 8'h40, -1, 8'h00);
    modelAccess(1'b1, 8'd0, 8'h40, -1, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'd1, 8'h00, -1, 8'h00);
    modelAccess(1'b1, 8'd1, 8'h00, -1, 8'h00);
    @(negedge clk);
    host_rd = 1'b1; host_addr = 8'd2;
    @(negedge clk);
    host_rd = 1'b0;
    host_wr = 1'b1; host_addr = 8'd0; host_wdata = 8'h77;
    @(negedge clk);
    host_wr = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hC3;
    @(negedge clk);
    mem_ack = 1'b0;
    modelAccess(1'b0, 8'd2, 8'h00, 1, 8'hC3);
    checks++; if (host_done !== 1'b1 || host_rdata !== 8'hC3) begin errors++; $display("[TB] FAIL mem_busy_read: done %b rdata %h expected 1 C3", host_done, host_rdata); end
    applyStimulus(1'b0, 1'b1, 8'd0, 8'h00, -1, 8'h00);
    modelAccess(1'b0, 8'd0, 8'h00, -1, 8'h00);
    checks++; if (lastRdata !== 8'h41 || lastRdata !== mRdata) begin errors++; $display("[TB] FAIL wr_during_mem_ignored: got %h expected 41", lastRdata); end
    applyStimulus(1'b1, 1'b0, 8'd3, 8'h01, -1, 8'h00);
    modelAccess(1'b1, 8'd3, 8'h01, -1, 8'h00);
    checks++; if (cpu_halt !== 1'b1) begin errors++; $display("[TB] FAIL cpu_halt_set: got %b expected 1", cpu_halt); end
    applyStimulus(1'b1, 1'b0, 8'd2, 8'h5C, 0, 8'h00);
    modelAccess(1'b1, 8'd2, 8'h5C, 0, 8'h00);
    checks++; if (mem_addr !== 16'h0041) begin errors++; $display("[TB] FAIL autoinc_off: got %h expected 0041", mem_addr); end
    applyStimulus(1'b0, 1'b1, 8'd3, 8'h00, -1, 8'h00);
    modelAccess(1'b0, 8'd3, 8'h00, -1, 8'h00);
    checks++; if (lastRdata !== 8'h01) begin errors++; $display("[TB] FAIL control_read: got %h expected 01", lastRdata); end
  endtask

  task automatic test_collisions();
    applyStimulus(1'b1, 1'b1, 8'd0, 8'h9E, -1, 8'h00);
    modelAccess(1'b1, 8'd0, 8'h9E, -1, 8'h00);
    checks++; if (lastRdata !== mRdata || mem_addr !== mPtr) begin errors++; $display("[TB] FAIL wr_rd_same_cycle: rdata %h ptr %h expected %h %h", lastRdata, mem_addr, mRdata, mPtr); end
    applyStimulus(1'b1, 1'b0, 8'd5, 8'hEE, -1, 8'h00);
    modelAccess(1'b1, 8'd5, 8'hEE, -1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'd5, 8'h00, -1, 8'h00);
    modelAccess(1'b0, 8'd5, 8'h00, -1, 8'h00);
    checks++; if (lastRdata !== 8'h00 || lastLatency !== 1) begin errors++; $display("[TB] FAIL unmapped_read: got %h latency %0d expected 00 latency 1", lastRdata, lastLatency); end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (busy !== 1'b0 || host_done !== 1'b0 || host_rdata !== mRdata) begin errors++; $display("[TB] FAIL stray_ack: busy %b done %b rdata %h expected 0 0 %h", busy, host_done, host_rdata, mRdata); end
  endtask

  task automatic test_random();
    logic        wr, rd;
    logic [7:0]  addr, wdata, memData;
    int          ackDelay, pick;
    logic [15:0] expAddr;
    for (int i = 0; i < 60; i++) begin
      wr   = 1'($urandom);
      rd   = !wr || 1'($urandom);
      pick = int'($urandom_range(0, 7));
      addr = (pick >= 5) ? 8'($urandom_range(5, 255)) : 8'(pick);
      if (pick == 6) addr = 8'd2;
      wdata    = 8'($urandom);
      memData  = 8'($urandom);
      ackDelay = int'($urandom_range(0, TIMEOUT + 1));
      expAddr  = mPtr;
      applyStimulus(wr, rd, addr, wdata, ackDelay, memData);
      checks++; if (lastLatency !== expLatency(addr, ackDelay) || lastPostDone !== 1'b0 || lastBusyOk !== 1'b1) begin errors++; $display("[TB] FAIL rand_timing[%0d]: latency %0d done_after %b busy_ok %b expected %0d 0 1", i, lastLatency, lastPostDone, lastBusyOk, expLatency(addr, ackDelay)); end
      if (addr == 8'd2) begin
        checks++; if (lastReqCycles !== expReqCycles(addr, ackDelay) || lastAddr !== expAddr || lastWe !== wr) begin errors++; $display("[TB] FAIL rand_mem[%0d]: req_cycles %0d addr %h we %b expected %0d %h %b", i, lastReqCycles, lastAddr, lastWe, expReqCycles(addr, ackDelay), expAddr, wr); end
      end
      modelAccess(wr, addr, wdata, ackDelay, memData);
      checks++; if (lastRdata !== mRdata || mem_addr !== mPtr || cpu_halt !== mCtrl[0]) begin errors++; $display("[TB] FAIL rand_state[%0d]: rdata %h ptr %h halt %b expected %h %h %b", i, lastRdata, mem_addr, cpu_halt, mRdata, mPtr, mCtrl[0]); end
    end
  endtask

  task automatic test_reset_in_mem();
    applyStimulus(1'b1, 1'b0, 8'd1, 8'h7C, -1, 8'h00);
    modelAccess(1'b1, 8'd1, 8'h7C, -1, 8'h00);
    @(negedge clk);
    host_rd = 1'b1; host_addr = 8'd2;
    @(negedge clk);
    host_rd = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_mem_entry: mem_req %b expected 1", mem_req); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || host_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_abort: req %b busy %b done %b expected 0 0 0", mem_req, busy, host_done); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (host_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_done[%0d]: got %b expected 0", k, host_done); end
    end
    checks++; if (mem_addr !== 16'h0000 || cpu_halt !== 1'b0) begin errors++; $display("[TB] FAIL rst_pointer: ptr %h halt %b expected 0000 0", mem_addr, cpu_halt); end
    applyStimulus(1'b0, 1'b1, 8'd3, 8'h00, -1, 8'h00);
    modelAccess(1'b0, 8'd3, 8'h00, -1, 8'h00);
    checks++; if (lastRdata !== 8'h02) begin errors++; $display("[TB] FAIL rst_control: got %h expected 02", lastRdata); end
  endtask

  // Test sequence.
  initial begin
    reset      = 1'b1;
    host_wr    = 1'b0;
    host_rd    = 1'b0;
    host_addr  = 8'h00;
    host_wdata = 8'h00;
    mem_rdata  = 8'h00;
    mem_ack    = 1'b0;
    modelReset();
    test_reset();
    test_pointer_regs();
    test_data_write();
    test_data_read_wrap();
    test_timeout();
    test_ignore_and_halt();
    test_collisions();
    test_random();
    test_reset_in_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
